// File: rtl/md5_cand_gen.sv
// md5_cand_gen -- decimal password candidate generator.
//
// Sweeps BCD candidates from low to high in increments of STEP and offers
// each one on a valid/ready handshake to a downstream hasher. An invalid
// range (non-decimal digit, or low > high) ends the sweep at once with err.
//
// Ports:
//   clk         system clock, rising edge
//   reset       synchronous, active-high
//   start       single-cycle sweep request (honoured only in IDLE)
//   stop        abort request (honoured only in RUN)
//   low, high   inclusive candidate range, BCD (4*DIGITS bits)
//   cand_valid  candidate offered
//   cand_ready  consumer accepts the offered candidate
//   cand_bcd    current candidate, BCD
//   busy        sweep in progress (CHECK, RUN or DONE)
//   done        one-cycle end-of-sweep pulse
//   err         last start had an invalid range
//   count       accepted candidates in this sweep, saturating
//   cand_ascii  (only with MD5_CAND_ASCII_EN) cand_bcd as ASCII digits,
//               most-significant digit in the top byte
//
// Build option: define MD5_CAND_ASCII_EN to add the cand_ascii output.
//
// state | meaning
// IDLE  | waiting for start
// CHECK | validate the latched range, load first candidate
// RUN   | offer candidates, step on each handshake
// DONE  | one-cycle done pulse, then back to IDLE

module md5_cand_gen #(
    parameter int DIGITS = 8,
    parameter int STEP   = 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic                stop,
    input  logic [4*DIGITS-1:0] low,
    input  logic [4*DIGITS-1:0] high,
    output logic                cand_valid,
    input  logic                cand_ready,
    output logic [4*DIGITS-1:0] cand_bcd,
    output logic                busy,
    output logic                done,
    output logic                err,
    output logic [31:0]         count
`ifdef MD5_CAND_ASCII_EN
    ,
    output logic [8*DIGITS-1:0] cand_ascii
`endif
);

    localparam int W = 4 * DIGITS;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CHECK = 2'd1,
        RUN   = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t         state_q, state_d;
    logic [W-1:0]   low_q, low_d;
    logic [W-1:0]   high_q, high_d;
    logic [W-1:0]   cand_q, cand_d;
    logic [31:0]    count_q, count_d;
    logic           err_q, err_d;

    logic [W:0]     inc;
    logic [W-1:0]   next_bcd;
    logic           next_carry;

    // Adds STEP to the least-significant digit with decimal carry ripple.
    // Bit W of the result is the carry out of the top digit.
    function automatic logic [W:0] bcd_inc(input logic [W-1:0] v);
        logic [W-1:0] r;
        logic         c;
        logic [4:0]   s;
        r = '0;
        c = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            if (i == 0)
                s = {1'b0, v[3:0]} + 5'(STEP);
            else
                s = {1'b0, v[4*i +: 4]} + {4'b0, c};
            if (s > 5'd9) begin
                s = s - 5'd10;
                c = 1'b1;
            end else begin
                c = 1'b0;
            end
            r[4*i +: 4] = s[3:0];
        end
        return {c, r};
    endfunction

    function automatic logic bcd_ok(input logic [W-1:0] v);
        logic ok;
        ok = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if (v[4*i +: 4] > 4'd9)
                ok = 1'b0;
        end
        return ok;
    endfunction

    assign inc        = bcd_inc(cand_q);
    assign next_bcd   = inc[W-1:0];
    assign next_carry = inc[W];

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            low_q   <= '0;
            high_q  <= '0;
            cand_q  <= '0;
            count_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            low_q   <= low_d;
            high_q  <= high_d;
            cand_q  <= cand_d;
            count_q <= count_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        low_d   = low_q;
        high_d  = high_q;
        cand_d  = cand_q;
        count_d = count_q;
        err_d   = err_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    low_d   = low;
                    high_d  = high;
                    count_d = '0;
                    err_d   = 1'b0;
                    state_d = CHECK;
                end
            end
            CHECK: begin
                // Valid BCD compares correctly as plain unsigned binary.
                if (!bcd_ok(low_q) || !bcd_ok(high_q) || (low_q > high_q)) begin
                    err_d   = 1'b1;
                    state_d = DONE;
                end else begin
                    cand_d  = low_q;
                    state_d = RUN;
                end
            end
            RUN: begin
                if (cand_ready) begin
                    if (count_q != 32'hFFFF_FFFF)
                        count_d = count_q + 32'd1;
                    if (next_carry || (next_bcd > high_q))
                        state_d = DONE;
                    else if (!stop)
                        cand_d = next_bcd;
                end
                // An accepted candidate in the same cycle still counts above;
                // the offered value is left as it was.
                if (stop)
                    state_d = DONE;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

`ifdef MD5_CAND_ASCII_EN
    function automatic logic [8*DIGITS-1:0] to_ascii(input logic [W-1:0] v);
        logic [8*DIGITS-1:0] r;
        r = '0;
        for (int i = 0; i < DIGITS; i++)
            r[8*i +: 8] = 8'h30 + {4'b0, v[4*i +: 4]};
        return r;
    endfunction

    logic [8*DIGITS-1:0] ascii_q;

    // Loaded from the same next value as cand_bcd so both change together.
    always_ff @(posedge clk) begin
        if (reset)
            ascii_q <= to_ascii('0);
        else
            ascii_q <= to_ascii(cand_d);
    end

    assign cand_ascii = ascii_q;
`endif

    assign cand_valid = (state_q == RUN);
    assign busy       = (state_q != IDLE);
    assign done       = (state_q == DONE);
    assign err        = err_q;
    assign count      = count_q;
    assign cand_bcd   = cand_q;

endmodule

// File: tb/tb_md5_cand_gen.sv
// Directed self-checking bench for md5_cand_gen (STEP=1 and STEP=3 instances).
module tb_md5_cand_gen;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        stop;
    logic [31:0] low;
    logic [31:0] high;
    logic        cand_ready;

    logic        cand_valid, busy, done, err;
    logic [31:0] cand_bcd, count;
    logic        cand_valid3, busy3, done3, err3;
    logic [31:0] cand_bcd3, count3;
`ifdef MD5_CAND_ASCII_EN
    logic [63:0] cand_ascii, cand_ascii3;
`endif

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    md5_cand_gen #(.DIGITS(8), .STEP(1)) dut (
        .clk(clk), .reset(reset), .start(start), .stop(stop),
        .low(low), .high(high), .cand_valid(cand_valid), .cand_ready(cand_ready),
        .cand_bcd(cand_bcd), .busy(busy), .done(done), .err(err), .count(count)
`ifdef MD5_CAND_ASCII_EN
        , .cand_ascii(cand_ascii)
`endif
    );

    md5_cand_gen #(.DIGITS(8), .STEP(3)) dut3 (
        .clk(clk), .reset(reset), .start(start), .stop(stop),
        .low(low), .high(high), .cand_valid(cand_valid3), .cand_ready(cand_ready),
        .cand_bcd(cand_bcd3), .busy(busy3), .done(done3), .err(err3), .count(count3)
`ifdef MD5_CAND_ASCII_EN
        , .cand_ascii(cand_ascii3)
`endif
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one clock; inputs change and outputs are sampled 1 ns after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [31:0] seq [5];
        seq[0] = 32'h0000_0098; seq[1] = 32'h0000_0099; seq[2] = 32'h0000_0100;
        seq[3] = 32'h0000_0101; seq[4] = 32'h0000_0102;

        reset = 1'b1; start = 1'b0; stop = 1'b0; low = '0; high = '0; cand_ready = 1'b0;
        step(); step();
        reset = 1'b0;
        check("rst_valid", cand_valid, 0);
        check("rst_bcd",   cand_bcd, 0);
        check("rst_busy",  busy, 0);
        check("rst_done",  done, 0);
        check("rst_err",   err, 0);
        check("rst_count", count, 0);
`ifdef MD5_CAND_ASCII_EN
        check("rst_ascii", cand_ascii, "00000000");
`endif

        // 98..102 with ready held high
        low = 32'h0000_0098; high = 32'h0000_0102; cand_ready = 1'b1; start = 1'b1;
        step();
        start = 1'b0;
        check("seq_busy_check", busy, 1);
        check("seq_valid_check", cand_valid, 0);
        step();
        for (int i = 0; i < 5; i++) begin
            check("seq_valid", cand_valid, 1);
            check("seq_bcd", cand_bcd, seq[i]);
            step();
        end
        check("seq_done", done, 1);
        check("seq_valid_end", cand_valid, 0);
        check("seq_count", count, 5);
        step();
        check("seq_done_1cyc", done, 0);
        check("seq_busy_idle", busy, 0);
        check("seq_count_hold", count, 5);
        check("seq_bcd_hold", cand_bcd, 32'h0000_0102);

        // STEP=3: top-digit carry ends the sweep after one candidate
        low = 32'h9999_9998; high = 32'h9999_9999; start = 1'b1;
        step();
        start = 1'b0;
        step();
        check("s3_valid", cand_valid3, 1);
        check("s3_bcd", cand_bcd3, 32'h9999_9998);
        step();
        check("s3_done", done3, 1);
        check("s3_count", count3, 1);
        check("s3_valid_end", cand_valid3, 0);
        check("s1_bcd_99999999", cand_bcd, 32'h9999_9999);
        step();
        check("s1_done", done, 1);
        check("s1_count", count, 2);
        step();

        // low > high
        low = 32'h0000_0010; high = 32'h0000_0005; start = 1'b1;
        step();
        start = 1'b0;
        check("rng_valid_c1", cand_valid, 0);
        check("rng_done_c1", done, 0);
        step();
        check("rng_done", done, 1);
        check("rng_err", err, 1);
        check("rng_count", count, 0);
        check("rng_valid", cand_valid, 0);
        step();
        check("rng_err_hold", err, 1);
        check("rng_done_1cyc", done, 0);

        // non-decimal digit in low
        low = 32'h0000_000A; high = 32'h0000_0020; start = 1'b1;
        step();
        start = 1'b0;
        step();
        check("dig_done", done, 1);
        check("dig_err", err, 1);
        check("dig_valid", cand_valid, 0);
        step();

        // ready toggling 1,0,1,0,1 with stop on the third handshake
        low = 32'h0000_0200; high = 32'h0000_0299; cand_ready = 1'b0; start = 1'b1;
        step();
        start = 1'b0;
        check("tog_err_cleared", err, 0);
        step();
        cand_ready = 1'b1;
        check("tog_bcd0", cand_bcd, 32'h0000_0200);
        step();
        cand_ready = 1'b0;
        check("tog_bcd1", cand_bcd, 32'h0000_0201);
        step();
        check("tog_stable1", cand_bcd, 32'h0000_0201);
        check("tog_valid1", cand_valid, 1);
        cand_ready = 1'b1;
        step();
        cand_ready = 1'b0;
        check("tog_bcd2", cand_bcd, 32'h0000_0202);
        step();
        check("tog_stable2", cand_bcd, 32'h0000_0202);
        cand_ready = 1'b1; stop = 1'b1;
        step();
        stop = 1'b0;
        check("tog_done", done, 1);
        check("tog_count", count, 3);
        check("tog_valid_drop", cand_valid, 0);
        check("tog_bcd_hold", cand_bcd, 32'h0000_0202);
        step();

        // reset mid-sweep, then a fresh sweep
        low = 32'h0000_0300; high = 32'h0000_0399; cand_ready = 1'b1; start = 1'b1;
        step();
        start = 1'b0;
        step(); step();
        check("abort_running", cand_valid, 1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("abort_done", done, 0);
        check("abort_valid", cand_valid, 0);
        check("abort_busy", busy, 0);
        check("abort_count", count, 0);
        check("abort_bcd", cand_bcd, 0);
        step();
        check("abort_done_next", done, 0);
        low = 32'h1234_5678; high = 32'h1234_5679; start = 1'b1;
        step();
        start = 1'b0;
        step();
        check("new_bcd0", cand_bcd, 32'h1234_5678);
`ifdef MD5_CAND_ASCII_EN
        check("new_ascii0", cand_ascii, "12345678");
`endif
        step();
        check("new_bcd1", cand_bcd, 32'h1234_5679);
`ifdef MD5_CAND_ASCII_EN
        check("new_ascii1", cand_ascii, "12345679");
`endif
        step();
        check("new_done", done, 1);
        check("new_count", count, 2);
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
